// File: rtl/spi_shift_engine.sv
// SPI mode-0 byte shifter: sends one of four command bytes MSB first and
// optionally captures the MISO byte clocked in during the same frame.
module spi_shift_engine #(
    parameter int         CLK_DIV   = 4,
    parameter logic [7:0] CMD_DUMMY = 8'h00,
    parameter logic [7:0] CMD_MEAS  = 8'h2D,
    parameter logic [7:0] CMD_READ  = 8'hB2,
    parameter logic [7:0] CMD_SRST  = 8'h52
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       transfer,
    input  logic       receive,
    input  logic [1:0] data_select,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       done,
    output logic       busy,
    output logic [7:0] rx_data,
    output logic       rx_valid
);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, DONE} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state, state_nx;
    logic [7:0] div_cnt, div_nx;
    logic [2:0] bit_cnt, bit_nx;
    logic [7:0] tx_sr, tx_nx;
    logic [7:0] rx_sr, rx_nx;
    logic       rx_en, rx_en_nx;
    logic       sclk_nx, mosi_nx, done_nx, busy_nx, rx_valid_nx;
    logic [7:0] rx_data_nx;
    logic [7:0] cmd_sel;
    logic       div_end;

    function automatic logic [7:0] cmd_byte(input logic [1:0] sel);
        case (sel)
            2'b00:   cmd_byte = CMD_DUMMY;
            2'b01:   cmd_byte = CMD_MEAS;
            2'b10:   cmd_byte = CMD_READ;
            default: cmd_byte = CMD_SRST;
        endcase
    endfunction

    assign cmd_sel = cmd_byte(data_select);
    assign div_end = (div_cnt == DIV_LAST);

    always_comb begin
        state_nx    = state;
        div_nx      = div_cnt;
        bit_nx      = bit_cnt;
        tx_nx       = tx_sr;
        rx_nx       = rx_sr;
        rx_en_nx    = rx_en;
        sclk_nx     = sclk;
        mosi_nx     = mosi;
        done_nx     = 1'b0;
        rx_valid_nx = 1'b0;
        rx_data_nx  = rx_data;
        case (state)
            IDLE: begin
                if (transfer) begin
                    state_nx = LEAD;
                    tx_nx    = cmd_sel;
                    rx_en_nx = receive;
                    bit_nx   = 3'd7;
                    div_nx   = 8'd0;
                    mosi_nx  = cmd_sel[7];
                end
            end
            LEAD: begin
                if (div_end) begin
                    state_nx = SHIFT;
                    div_nx   = 8'd0;
                    sclk_nx  = 1'b1;
                    rx_nx    = {rx_sr[6:0], miso};
                end else begin
                    div_nx = div_cnt + 8'd1;
                end
            end
            SHIFT: begin
                if (!div_end) begin
                    div_nx = div_cnt + 8'd1;
                end else if (sclk) begin
                    div_nx  = 8'd0;
                    sclk_nx = 1'b0;
                    // The 8th falling edge arrives with bit_cnt already 0: mosi keeps bit 0.
                    if (bit_cnt != 3'd0) begin
                        tx_nx   = {tx_sr[6:0], 1'b0};
                        mosi_nx = tx_sr[6];
                    end
                end else if (bit_cnt == 3'd0) begin
                    state_nx = TRAIL;
                    div_nx   = 8'd0;
                end else begin
                    div_nx  = 8'd0;
                    bit_nx  = bit_cnt - 3'd1;
                    sclk_nx = 1'b1;
                    rx_nx   = {rx_sr[6:0], miso};
                end
            end
            TRAIL: begin
                if (div_end) begin
                    state_nx = DONE;
                    div_nx   = 8'd0;
                    done_nx  = 1'b1;
                    if (rx_en) begin
                        rx_valid_nx = 1'b1;
                        rx_data_nx  = rx_sr;
                    end
                end else begin
                    div_nx = div_cnt + 8'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= 8'd0;
            bit_cnt  <= 3'd0;
            rx_en    <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
        end else begin
            state    <= state_nx;
            div_cnt  <= div_nx;
            bit_cnt  <= bit_nx;
            rx_en    <= rx_en_nx;
            sclk     <= sclk_nx;
            mosi     <= mosi_nx;
            done     <= done_nx;
            busy     <= busy_nx;
            rx_valid <= rx_valid_nx;
            rx_data  <= rx_data_nx;
        end
    end

    // Shift registers carry data only; a frame always reloads them before use.
    always_ff @(posedge clk) begin
        tx_sr <= tx_nx;
        rx_sr <= rx_nx;
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: a scoreboard queue holds each frame's
// expected byte, rx result and done cycle; a negedge monitor checks at done.
module tb_spi_shift_engine;

    logic       clk;
    logic       rst;
    logic       transfer;
    logic       receive;
    logic [1:0] data_select;
    logic       miso;
    logic       sclk;
    logic       mosi;
    logic       done;
    logic       busy;
    logic [7:0] rx_data;
    logic       rx_valid;

    typedef struct {
        logic [7:0] tx;
        logic       rx_en;
        logic [7:0] rx;
        int         done_cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int passed;
    int total;
    int cyc;
    int dones_seen;
    int rxv_seen;
    int exp_dones;
    int exp_rxv;
    int c0;

    logic [7:0] last_rx;
    logic [7:0] slave_byte;
    logic [7:0] mosi_bits;
    int         rise_cnt;
    logic [2:0] fall_cnt;
    logic       sclk_prev;
    logic       busy_prev;

    spi_shift_engine #(.CLK_DIV(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .transfer    (transfer),
        .receive     (receive),
        .data_select (data_select),
        .miso        (miso),
        .sclk        (sclk),
        .mosi        (mosi),
        .done        (done),
        .busy        (busy),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: presents bit 7 before the frame, next bit after each sclk fall.
    assign miso = slave_byte[3'd7 - fall_cnt];

    function automatic logic [7:0] cmd_of(input logic [1:0] sel);
        case (sel)
            2'b00:   cmd_of = 8'h00;
            2'b01:   cmd_of = 8'h2D;
            2'b10:   cmd_of = 8'hB2;
            default: cmd_of = 8'h52;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] ds, input logic rcv, input logic [7:0] slave,
                            input int done_at);
        exp_t e;
        if (rcv) last_rx = slave;
        e.tx       = cmd_of(ds);
        e.rx_en    = rcv;
        e.rx       = last_rx;
        e.done_cyc = done_at;
        q.push_back(e);
        exp_dones++;
        if (rcv) exp_rxv++;
    endtask

    // Request one frame, then scramble the inputs so any mid-frame sampling shows up.
    task automatic start_frame(input logic [1:0] ds, input logic rcv, input logic [7:0] slave);
        slave_byte  = slave;
        data_select = ds;
        receive     = rcv;
        transfer    = 1'b1;
        push_exp(ds, rcv, slave, cyc + 73);
        @(negedge clk);
        transfer    = 1'b0;
        data_select = ~ds;
        receive     = ~rcv;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("frame_timeout", q.size(), 0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (busy && !busy_prev) begin
            rise_cnt  = 0;
            mosi_bits = 8'h00;
        end
        if (sclk && !sclk_prev) begin
            mosi_bits = {mosi_bits[6:0], mosi};
            rise_cnt++;
        end
        if (!busy) fall_cnt = 3'd0;
        else if (!sclk && sclk_prev && fall_cnt != 3'd7) fall_cnt++;
        if (rx_valid) rxv_seen++;
        if (done) begin
            dones_seen++;
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = q.pop_front();
                check("done_cycle", cyc, mon_e.done_cyc);
                check("mosi_byte", mosi_bits, mon_e.tx);
                check("sclk_rises", rise_cnt, 8);
                check("rx_valid_at_done", rx_valid, mon_e.rx_en);
                check("rx_data_at_done", rx_data, mon_e.rx);
            end
        end
        sclk_prev = sclk;
        busy_prev = busy;
    end

    initial begin
        passed = 0; total = 0;
        dones_seen = 0; rxv_seen = 0; exp_dones = 0; exp_rxv = 0;
        last_rx = 8'h00; slave_byte = 8'h00; mosi_bits = 8'h00;
        rise_cnt = 0; fall_cnt = 3'd0; sclk_prev = 1'b0; busy_prev = 1'b0;
        rst = 1'b1; transfer = 1'b0; receive = 1'b0; data_select = 2'b00;

        repeat (3) @(negedge clk);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // Measure command, no receive: 2D on mosi, rx_data keeps its reset value.
        start_frame(2'b01, 1'b0, 8'h5A);
        check("lead_busy", busy, 1);
        check("lead_sclk", sclk, 0);
        check("lead_mosi", mosi, 0);
        wait_idle();

        // Dummy command while receiving A5.
        start_frame(2'b00, 1'b1, 8'hA5);
        wait_idle();

        // Receive disabled after the A5 frame: rx_data must still read A5.
        start_frame(2'b11, 1'b0, 8'h3C);
        wait_idle();
        check("rx_hold_after_norx", rx_data, 8'hA5);

        // Transfer held high across two frames while data_select changes mid-frame.
        data_select = 2'b10;
        receive     = 1'b0;
        transfer    = 1'b1;
        c0          = cyc;
        push_exp(2'b10, 1'b0, 8'h00, c0 + 73);
        push_exp(2'b11, 1'b0, 8'h00, c0 + 147);
        repeat (20) @(negedge clk);
        data_select = 2'b11;
        repeat (54) @(negedge clk);
        check("gap_busy", busy, 0);
        check("gap_sclk", sclk, 0);
        repeat (26) @(negedge clk);
        data_select = 2'b01;
        transfer    = 1'b0;
        wait_idle();

        // Reset 30 cycles into a receiving frame: aborted, no done, no rx_valid.
        start_frame(2'b01, 1'b1, 8'hFF);
        void'(q.pop_back());
        exp_dones--;
        exp_rxv--;
        last_rx = 8'h00;
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_sclk", sclk, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_rx_valid", rx_valid, 0);
        check("abort_rx_data", rx_data, 8'h00);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        check("abort_no_done", dones_seen, exp_dones);

        // A fresh frame after the abort runs normally.
        start_frame(2'b10, 1'b1, 8'h3C);
        wait_idle();

        check("done_pulses", dones_seen, exp_dones);
        check("rx_valid_pulses", rxv_seen, exp_rxv);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
